// File: rtl/led_clock_gen.sv
// LED clock generator: divides Clock_50 down to a selectable 0.5/1/2/4 Hz
// square wave, with debounced Pause and Step pushbuttons driving a
// RUN / PAUSED / STEP controller that can freeze or single-step the wave.
module led_clock_gen #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic [1:0] Speed_sel,
  input  logic       Pause_btn,
  input  logic       Step_btn,
  output logic       Clock_1Hz,
  output logic       Tick,
  output logic       Running
);

  // Counter must hold CLK_FREQ-1, the longest half-period (0.5 Hz).
  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Terminal counts (half-period minus one) for each speed setting.
  localparam logic [CW-1:0] LAST_1HZ  = CW'(CLK_FREQ / 2 - 1);
  localparam logic [CW-1:0] LAST_2HZ  = CW'(CLK_FREQ / 4 - 1);
  localparam logic [CW-1:0] LAST_4HZ  = CW'(CLK_FREQ / 8 - 1);
  localparam logic [CW-1:0] LAST_05HZ = CW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     count;
  logic [CW-1:0]     last;
  logic [1:0]        speed;
  logic              advance;
  logic              terminal;
  logic              rise;

  // Button path; index 0 is Pause, index 1 is Step.
  logic [1:0]         btn_raw;
  logic [1:0]         sync_a;
  logic [1:0]         sync_b;
  logic [1:0]         stable;
  logic [1:0][DW-1:0] db_cnt;
  logic [1:0]         press;
  logic               pause_ev;
  logic               step_ev;

  assign btn_raw  = {Step_btn, Pause_btn};
  assign pause_ev = press[0];
  assign step_ev  = press[1];

  // Select the terminal count from the speed latched at the last wrap.
  always_comb begin
    last = LAST_1HZ;
    case (speed)
      2'b00:   last = LAST_1HZ;
      2'b01:   last = LAST_2HZ;
      2'b10:   last = LAST_4HZ;
      default: last = LAST_05HZ;
    endcase
  end

  assign advance  = (state != PAUSED);
  assign terminal = advance && (count == last);
  assign rise     = terminal && !Clock_1Hz;

  // Half-period counter, square wave, tick pulse and speed latch.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      count     <= '0;
      Clock_1Hz <= 1'b0;
      Tick      <= 1'b0;
      speed     <= 2'b00;
    end else begin
      Tick <= rise;
      if (advance) begin
        if (terminal) begin
          count     <= '0;
          Clock_1Hz <= ~Clock_1Hz;
          // New speed only takes effect from the next half-period.
          speed     <= Speed_sel;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

  // Two-flop synchronizers, debouncers and press-event detection.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
      stable <= 2'b11;
      db_cnt <= '0;
      press  <= 2'b00;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // Enough consecutive differing samples: accept the new level.
          stable[i] <= sync_b[i];
          db_cnt[i] <= '0;
          press[i]  <= ~sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Next-state rules; Pause always wins over Step and over step completion.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (pause_ev) state_next = PAUSED;
      end
      PAUSED: begin
        if (pause_ev)     state_next = RUN;
        else if (step_ev) state_next = STEP;
      end
      STEP: begin
        if (pause_ev)  state_next = RUN;
        else if (rise) state_next = PAUSED;
      end
      default: state_next = RUN;
    endcase
  end

  // Controller state with a registered Running flag.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state   <= RUN;
      Running <= 1'b1;
    end else begin
      state   <= state_next;
      Running <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_led_clock_gen.sv
// Bench for led_clock_gen with a small clock and short debounce so that
// every timing rule can be observed cycle by cycle.
module tb_led_clock_gen;

  localparam int CLK_FREQ = 16;
  localparam int DB       = 4;

  logic       Clock_50 = 1'b0;
  logic       Resetn   = 1'b1;
  logic [1:0] Speed_sel = 2'b00;
  logic       Pause_btn = 1'b1;
  logic       Step_btn  = 1'b1;
  logic       Clock_1Hz;
  logic       Tick;
  logic       Running;

  int vectors     = 0;
  int miscompares = 0;
  int now         = 0;

  led_clock_gen #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_CYCLES(DB)) dut (
    .Clock_50  (Clock_50),
    .Resetn    (Resetn),
    .Speed_sel (Speed_sel),
    .Pause_btn (Pause_btn),
    .Step_btn  (Step_btn),
    .Clock_1Hz (Clock_1Hz),
    .Tick      (Tick),
    .Running   (Running)
  );

  always #5 Clock_50 = ~Clock_50;

  typedef struct {
    int   cyc;
    logic clk;
    logic tick;
    logic run;
  } vec_t;

  vec_t tbl [10];

  // ---------------- reference model ----------------
  localparam int M_RUN = 0, M_PAUSED = 1, M_STEP = 2;
  int          m_st;
  int          m_pos;
  int          m_sel;
  bit          m_lvl, m_tick, m_run;
  bit          m_pev, m_sev;
  bit          m_stab [2];
  logic [15:0] m_hist [2];

  function automatic int half_len(input int sel);
    case (sel)
      0:       return CLK_FREQ / 2;   // 1 Hz
      1:       return CLK_FREQ / 4;   // 2 Hz
      2:       return CLK_FREQ / 8;   // 4 Hz
      default: return CLK_FREQ;       // 0.5 Hz
    endcase
  endfunction

  task model_reset();
    m_st = M_RUN; m_pos = 0; m_sel = 0;
    m_lvl = 0; m_tick = 0; m_run = 1;
    m_pev = 0; m_sev = 0;
    for (int b = 0; b < 2; b++) begin
      m_stab[b] = 1;
      m_hist[b] = '1;
    end
  endtask

  // A button level is accepted once the last DB synchronized samples
  // (raw values delayed two clocks) all disagree with the current level.
  task automatic model_button(input int b, input bit raw, output bit ev);
    logic [DB-1:0] win;
    ev = 0;
    m_hist[b] = {m_hist[b][14:0], raw};
    win = m_hist[b][DB+1:2];
    if (m_stab[b] && win == '0) begin
      m_stab[b] = 0;
      ev = 1;
    end else if (!m_stab[b] && (&win)) begin
      m_stab[b] = 1;
    end
  endtask

  task model_step();
    bit adv, term, pe, se, ep, es;
    int st_n;
    pe   = m_pev;
    se   = m_sev;
    adv  = (m_st != M_PAUSED);
    term = adv && (m_pos + 1 == half_len(m_sel));
    m_tick = term && !m_lvl;
    st_n = m_st;
    case (m_st)
      M_RUN:    if (pe) st_n = M_PAUSED;
      M_PAUSED: if (pe) st_n = M_RUN; else if (se) st_n = M_STEP;
      default:  if (pe) st_n = M_RUN; else if (m_tick) st_n = M_PAUSED;
    endcase
    if (adv) begin
      if (term) begin
        m_pos = 0;
        m_lvl = !m_lvl;
        m_sel = int'(Speed_sel);
      end else begin
        m_pos++;
      end
    end
    m_st  = st_n;
    m_run = (st_n == M_RUN);
    model_button(0, Pause_btn, ep);
    model_button(1, Step_btn, es);
    m_pev = ep;
    m_sev = es;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (t=%0t cyc=%0d): got %0h expected %0h", name, $time, now, act, exp);
    end
  endtask

  task automatic goto(input int t);
    while (now < t) begin
      @(posedge Clock_50);
      @(negedge Clock_50);
      now++;
    end
  endtask

  // Called at a falling edge; returns at the falling edge where reset is released (cycle 0).
  task automatic do_reset(input string tag);
    Resetn    = 1'b0;
    Pause_btn = 1'b1;
    Step_btn  = 1'b1;
    Speed_sel = 2'b00;
    #1;
    check({tag, "_rst_clk"},  Clock_1Hz, 0);
    check({tag, "_rst_tick"}, Tick,      0);
    check({tag, "_rst_run"},  Running,   1);
    model_reset();
    @(negedge Clock_50);
    @(negedge Clock_50);
    Resetn = 1'b1;
    now = 0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      goto(tbl[i].cyc);
      check($sformatf("%s_c%0d_clk", tag, tbl[i].cyc),  Clock_1Hz, tbl[i].clk);
      check($sformatf("%s_c%0d_tick", tag, tbl[i].cyc), Tick,      tbl[i].tick);
      check($sformatf("%s_c%0d_run", tag, tbl[i].cyc),  Running,   tbl[i].run);
    end
  endtask

  initial begin
    int ticks;
    int p_hold, s_hold;

    // Timing after reset at 1 Hz: rise (with Tick) every 16 clocks, falls in between.
    tbl[0] = '{0,  1'b0, 1'b0, 1'b1};
    tbl[1] = '{7,  1'b0, 1'b0, 1'b1};
    tbl[2] = '{8,  1'b1, 1'b1, 1'b1};
    tbl[3] = '{9,  1'b1, 1'b0, 1'b1};
    tbl[4] = '{15, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{16, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{23, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{24, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{25, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{32, 1'b0, 1'b0, 1'b1};

    @(negedge Clock_50);

    // Basic divide timing.
    do_reset("base");
    run_table("base");

    // Speed change mid half-period only affects the following halves.
    do_reset("spd");
    goto(3);  Speed_sel = 2'b01;
    goto(7);  check("spd_c7_clk",   Clock_1Hz, 0);
    goto(8);  check("spd_c8_clk",   Clock_1Hz, 1);
              check("spd_c8_tick",  Tick,      1);
    goto(11); check("spd_c11_clk",  Clock_1Hz, 1);
    goto(12); check("spd_c12_clk",  Clock_1Hz, 0);
    goto(16); check("spd_c16_clk",  Clock_1Hz, 1);
              check("spd_c16_tick", Tick,      1);
    goto(17); check("spd_c17_tick", Tick,      0);
    goto(20); check("spd_c20_clk",  Clock_1Hz, 0);
    goto(24); check("spd_c24_tick", Tick,      1);

    // Short glitch ignored; long press pauses; counter position preserved.
    do_reset("pause");
    Pause_btn = 1'b0;
    goto(2);  Pause_btn = 1'b1;
    goto(6);  check("pause_glitch_run", Running, 1);
    Pause_btn = 1'b0;
    goto(13); check("pause_run_off", Running, 0);
              check("pause_clk_hi",  Clock_1Hz, 1);
    goto(16); Pause_btn = 1'b1;
    for (int t = 17; t <= 33; t++) begin
      goto(t);
      check("pause_frozen_clk",  Clock_1Hz, 1);
      check("pause_frozen_tick", Tick,      0);
    end
    Pause_btn = 1'b0;
    goto(41); Pause_btn = 1'b1;
    goto(42); check("resume_run",      Running,   1);
              check("resume_clk_hold", Clock_1Hz, 1);
    goto(43); check("resume_clk_fall", Clock_1Hz, 0);

    // Single step from PAUSED with the wave low.
    do_reset("step");
    Pause_btn = 1'b0;
    goto(8);  Pause_btn = 1'b1;
    goto(12); check("step_paused_run", Running,   0);
              check("step_paused_clk", Clock_1Hz, 0);
    Step_btn = 1'b0;
    ticks = 0;
    for (int t = 13; t <= 40; t++) begin
      goto(t);
      if (t == 20) Step_btn = 1'b1;
      ticks += int'(Tick);
      check("step_run_low", Running, 0);
    end
    check("step_tick_count", ticks,     1);
    check("step_clk_after",  Clock_1Hz, 1);

    // Simultaneous Pause and Step while PAUSED: Pause wins.
    Pause_btn = 1'b0;
    Step_btn  = 1'b0;
    goto(48); Pause_btn = 1'b1; Step_btn = 1'b1;
    goto(49); check("both_run",      Running,   1);
    goto(54); check("both_clk_hold", Clock_1Hz, 1);
    goto(55); check("both_clk_fall", Clock_1Hz, 0);

    // Reset in the middle of a step.
    do_reset("mid");
    goto(8);  check("mid_clk_hi", Clock_1Hz, 1);
    Pause_btn = 1'b0;
    goto(16); Pause_btn = 1'b1;
    goto(17); Step_btn = 1'b0;
    goto(24); check("mid_step_run", Running,   0);
              check("mid_step_clk", Clock_1Hz, 1);
    do_reset("mid");
    run_table("mid_after");

    // Randomized run against the reference model.
    do_reset("rnd");
    p_hold = 0;
    s_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        Resetn = 1'b0;
        #1;
        model_reset();
        check("rnd_rst_clk",  Clock_1Hz, 0);
        check("rnd_rst_tick", Tick,      0);
        check("rnd_rst_run",  Running,   1);
        @(negedge Clock_50);
        Resetn = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) Speed_sel = 2'($urandom_range(0, 3));
      if (p_hold == 0) begin
        Pause_btn = ~Pause_btn;
        p_hold = $urandom_range(1, 14);
      end else begin
        p_hold--;
      end
      if (s_hold == 0) begin
        Step_btn = ~Step_btn;
        s_hold = $urandom_range(1, 14);
      end else begin
        s_hold--;
      end
      @(posedge Clock_50);
      model_step();
      @(negedge Clock_50);
      check("rnd_clk",  Clock_1Hz, m_lvl);
      check("rnd_tick", Tick,      m_tick);
      check("rnd_run",  Running,   m_run);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_clock_gen.md
LED_CLOCK_GEN -- requirements
Module: led_clock_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms), the number of consecutive stable samples required to accept a button level.
REQ-003 SHALL have port Clock_50, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port Resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port Speed_sel, input, 2 bits: 00=1 Hz, 01=2 Hz, 10=4 Hz, 11=0.5 Hz.
REQ-006 SHALL have port Pause_btn, input, 1 bit: raw pushbutton, active-low, asynchronous to Clock_50.
REQ-007 SHALL have port Step_btn, input, 1 bit: raw pushbutton, active-low, asynchronous to Clock_50.
REQ-008 SHALL have port Clock_1Hz, output, 1 bit: registered square wave that feeds the LED pattern stage.
REQ-009 SHALL have port Tick, output, 1 bit: one-cycle pulse in the same cycle Clock_1Hz rises.
REQ-010 SHALL have port Running, output, 1 bit: 1 only in the RUN state.

Function
REQ-011 SHALL compute the half-period HALF = CLK_FREQ/(2*f) from the latched speed: 1 Hz gives CLK_FREQ/2, 2 Hz gives CLK_FREQ/4, 4 Hz gives CLK_FREQ/8, 0.5 Hz gives CLK_FREQ.
REQ-012 SHALL use a counter sized for CLK_FREQ-1 that counts 0..HALF-1 while advancing; at HALF-1 it toggles Clock_1Hz and wraps to 0.
REQ-013 SHALL sample Speed_sel into the latched speed only on the terminal-count cycle, so a speed change never truncates or extends the half-period in progress.
REQ-014 SHALL pass each button through a 2-flop synchronizer, then a debouncer that updates its stable level only after DEBOUNCE_CYCLES identical consecutive samples.
REQ-015 SHALL generate one press event per debounced 1->0 transition; a release generates no event, and a held button generates no further events.
REQ-016 SHALL implement an FSM with the states RUN, PAUSED and STEP.
REQ-017 SHALL advance the counter in RUN and STEP, and freeze both the counter and Clock_1Hz in PAUSED.
REQ-018 SHALL apply these RUN transitions: a Pause event goes to PAUSED; a Step event is ignored.
REQ-019 SHALL apply these PAUSED transitions: a Pause event goes to RUN; a Step event goes to STEP.
REQ-020 SHALL apply these STEP transitions: the cycle that asserts Tick goes to PAUSED; a Pause event goes to RUN, aborting the step.
REQ-021 SHALL give the Pause event priority when Pause and Step events occur in the same cycle; Step is then discarded.
REQ-022 SHALL assert Tick only when Clock_1Hz goes 0->1, so no Tick is possible in PAUSED.
REQ-023 SHALL keep Clock_1Hz, Tick and Running glitch-free, each driven directly from a flop.

Reset
REQ-024 SHALL, on Resetn=0, immediately and regardless of the clock set: Clock_1Hz=0, Tick=0, counter=0, state=RUN, Running=1, latched speed=00, synchronizer and debouncer levels=1 (released), debounce counters=0.
REQ-025 SHALL, after Resetn deasserts, start counting on the first Clock_50 rising edge.
REQ-026 SHALL, if reset is asserted mid-STEP or mid-debounce, abandon the step or debounce entirely; no event is generated after release.

Verification (CLK_FREQ=16, DEBOUNCE_CYCLES=4, Speed_sel=00 unless stated)
REQ-027 SHALL cover: reset release -> Clock_1Hz rises after 8 clocks and falls after 16; Tick is high exactly 1 cycle every 16 clocks, coincident with the rise.
REQ-028 SHALL cover: Speed_sel changed to 01 at clock 3 of a half-period -> that half lasts 8 clocks; following halves last 4 clocks; Tick every 8 clocks.
REQ-029 SHALL cover: Pause_btn low for 2 clocks -> no state change, Running=1; then Pause_btn low for 10 clocks -> Running=0 within 7 clocks of the press, and Clock_1Hz and the counter are frozen.
REQ-030 SHALL cover: PAUSED with Clock_1Hz=0, Step pressed -> exactly one Tick, the FSM returns to PAUSED with Clock_1Hz=1, and Running stays 0 throughout.
REQ-031 SHALL cover: Pause and Step events in the same cycle while PAUSED -> RUN, no STEP entry, Running=1.
REQ-032 SHALL cover: Resetn pulsed low mid-STEP -> Clock_1Hz=0, Tick=0, Running=1 asynchronously, and after release the 8/16-clock timing of REQ-027 is repeated.
